// File: rtl/fifo_read_ctrl.sv
// Read-side controller for a synchronous FIFO. A two-entry skid buffer hides the
// FIFO's one-cycle read latency behind a valid/ready stream, with flush and counters.
module fifo_read_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  flush_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [7:0]            underflow_count
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pend_q, pend_d;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic                  flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [7:0]            uf_count_q, uf_count_d;

    logic       pop;
    logic       capture;
    logic       flush_start;
    logic       flush_exit;
    logic [2:0] in_flight;

    assign flush_start = flush && (state_q != FLUSH);
    assign flush_exit  = (state_q == FLUSH) && fifo_empty && !pend_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a flush request overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)     state_d = STREAM;
            STREAM:  if (!enable)    state_d = IDLE;
            FLUSH:   if (flush_exit) state_d = enable ? STREAM : IDLE;
            default:                 state_d = IDLE;
        endcase
        if (flush_start) state_d = FLUSH;
    end

    // Outputs. A read is only issued in STREAM when the word it returns is
    // guaranteed a buffer slot, counting this cycle's pop as a freed slot.
    always_comb begin
        m_valid    = (occ_q != 2'd0) && (state_q != FLUSH);
        pop        = m_valid && m_ready;
        busy       = (state_q == FLUSH) || pend_q || (occ_q != 2'd0);
        in_flight  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
        fifo_rd_en = 1'b0;
        case (state_q)
            STREAM:  fifo_rd_en = !fifo_empty && (in_flight < 3'd2);
            FLUSH:   fifo_rd_en = !fifo_empty;
            default: fifo_rd_en = 1'b0;
        endcase
        // Never consume a FIFO word whose return the reset is about to drop.
        if (rst) fifo_rd_en = 1'b0;
    end

    // Skid buffer: head is the presented word, tail is the second entry.
    always_comb begin
        capture      = pend_q && !fifo_underflow && (state_q != FLUSH);
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        case ({pop, capture})
            2'b10: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd0) head_d = fifo_data_out;
                else               tail_d = fifo_data_out;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end
            end
            default: ;
        endcase
        if (flush_start) occ_d = 2'd0;

        pend_d       = fifo_rd_en;
        flush_done_d = flush_exit;
        rd_count_d   = rd_count_q + CNT_WIDTH'(pop);
        uf_count_d   = uf_count_q;
        if (pend_q && fifo_underflow && (uf_count_q != 8'hFF)) uf_count_d = uf_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= 2'd0;
            pend_q       <= 1'b0;
            // NOTE: the data entries are reset too, because m_data must read 0 after reset.
            head_q       <= '0;
            tail_q       <= '0;
            flush_done_q <= 1'b0;
            rd_count_q   <= '0;
            uf_count_q   <= 8'd0;
        end else begin
            occ_q        <= occ_d;
            pend_q       <= pend_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            flush_done_q <= flush_done_d;
            rd_count_q   <= rd_count_d;
            uf_count_q   <= uf_count_d;
        end
    end

    assign m_data          = head_q;
    assign flush_done      = flush_done_q;
    assign rd_count        = rd_count_q;
    assign underflow_count = uf_count_q;

endmodule
